// File: rtl/mux_rr_pipe_if.sv
// Handshake bundle for mux_rr_pipe: CHANNELS producer lanes in, one consumer lane out.
// The producer side (in_data/in_valid/in_last) and the consumer's out_ready are
// driven through the master modport; the mux itself sits on the slave modport.
// Optional macro MUX_RR_PIPE_LOCK_EN adds the per-channel in_last lane.
interface mux_rr_pipe_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
`ifdef MUX_RR_PIPE_LOCK_EN
  logic [CHANNELS-1:0]       in_last;
`endif
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_src;
  logic                      out_valid;
  logic                      out_ready;

`ifdef MUX_RR_PIPE_LOCK_EN
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
`endif
endinterface

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: N-channel round-robin arbitrated mux with one registered output
// stage and full-throughput backpressure (load = !out_valid || out_ready).
// Optional macro MUX_RR_PIPE_LOCK_EN: a transfer with in_last=0 locks arbitration
// to that channel until its in_last=1 word transfers.
module mux_rr_pipe #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux_rr_pipe_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW1   = SEL_W + 1;
  localparam int PAD   = 1 << SEL_W;
  localparam logic [SEL_W:0]   CH_EXT  = SW1'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W:0]   idx;
  logic [PAD-1:0]   valid_pad;
  logic [PAD-1:0]   grant_pad;
  logic [WIDTH-1:0] sel_data;
  logic             load;
  logic             found;
  logic             xfer;
`ifdef MUX_RR_PIPE_LOCK_EN
  logic             lock_on;
  logic [SEL_W-1:0] lock_ch;
`endif

  assign load    = !bus.out_valid || bus.out_ready;
  assign xfer    = load && found;
  // Wrap explicitly so non-power-of-2 channel counts never leave ptr out of range.
  assign ptr_nxt = (winner == LAST_CH) ? '0 : winner + 1'b1;

  // Round-robin search from ptr upward, wrapping past the last channel.
  always_comb begin
    valid_pad = '0;
    valid_pad[CHANNELS-1:0] = bus.in_valid;
    found  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, ptr} + SW1'(k);
      if (idx >= CH_EXT) idx = idx - CH_EXT;
      if (!found && valid_pad[idx[SEL_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[SEL_W-1:0];
      end
    end
`ifdef MUX_RR_PIPE_LOCK_EN
    // A locked burst owns the output even while its channel is idle.
    if (lock_on) begin
      winner = lock_ch;
      found  = valid_pad[lock_ch];
    end
`endif
  end

  // One-hot grant (held off during reset) and selection of the winning word.
  always_comb begin
    grant_pad = '0;
    sel_data  = '0;
    if (rst_n && xfer) grant_pad[winner] = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (winner == SEL_W'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready = grant_pad[CHANNELS-1:0];

  // Output register and arbitration state; a stall holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      ptr           <= '0;
`ifdef MUX_RR_PIPE_LOCK_EN
      lock_on       <= 1'b0;
      lock_ch       <= '0;
`endif
    end else if (load) begin
      if (found) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= sel_data;
        bus.out_src   <= winner;
`ifdef MUX_RR_PIPE_LOCK_EN
        if (bus.in_last[winner]) begin
          lock_on <= 1'b0;
          ptr     <= ptr_nxt;
        end else begin
          lock_on <= 1'b1;
          lock_ch <= winner;
        end
`else
        ptr <= ptr_nxt;
`endif
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
